ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the three-stage RV32I pipeline (F/D -> E -> W); sits directly downstream of the fetch/decode stage.
- Consumes the registered decode bundle and performs ALU operations, branch/jump resolution and data-memory load/store.
- Produces a registered writeback bundle for W, a PC redirect for fetch, and a stall back to decode while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESETVEC, 32'h0000_0000, reset value of the internal PC and of redirect_pc.

Ports:
- clk  in  1  pipeline clock
- resetb  in  1  asynchronous, active-low reset
- id_valid  in  1  decode bundle valid this cycle
- id_pc  in  32  PC of the decoded instruction
- id_imm  in  32  decoded immediate
- id_imm_sel  in  1  ALU operand B = imm (else rs2 data)
- id_rs1_data  in  32  register-file read of rs1
- id_rs2_data  in  32  register-file read of rs2
- id_dst  in  5  rd index
- id_alu_op  in  3  funct3
- id_subtype  in  1  SUB/SRA select
- id_memwr, id_mem2reg, id_alu, id_lui, id_auipc, id_jal, id_jalr, id_branch  in  1 each  one-hot class flags
- ex_stall  out  1  decode must hold its bundle
- redirect  out  1  one-cycle pulse, fetch must load redirect_pc
- redirect_pc  out  32  new fetch PC
- dmem_ready  out  1  data request strobe, held until accepted
- dmem_valid  in  1  request completed; rdata is valid this cycle
- dmem_addr  out  32  word-aligned address
- dmem_rw  out  1  1 = write
- dmem_wstrb  out  4  byte enables
- dmem_wdata  out  32  lane-aligned write data
- dmem_rdata  in  32  read data
- wb_valid  out  1  writeback valid
- wb_dst  out  5  writeback register
- wb_data  out  32  writeback value
- ex_exception  out  1  sticky fault flag

Behaviour:
- Reset (resetb low, asynchronous): all outputs 0; redirect_pc = RESETVEC; FSM = IDLE; exception flag cleared. A reset in MEM_WAIT abandons the access; a dmem_valid arriving after reset is ignored.
- FSM states: IDLE, MEM_WAIT.
- IDLE:
  - A bundle is accepted when id_valid=1 and the squash flag is clear.
  - ALU/LUI/AUIPC/JAL/JALR: result registered; wb_valid=1 on the next cycle. Latency 1.
  - ALU: operand A = rs1; operand B = imm_sel ? imm : rs2.
  - funct3 mapping: 000 ADD/SUB (subtype=1 -> SUB); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA (subtype=1 -> SRA); 110 OR; 111 AND. Shift amount is operand B[4:0]. All arithmetic wraps modulo 2^32.
  - LUI -> imm. AUIPC -> pc+imm. JAL/JALR -> pc+4 written to rd.
  - Branch: funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Branches never write back.
  - Redirect targets: taken branch or JAL -> pc+imm; JALR -> (rs1+imm) & ~1. redirect pulses on the cycle after acceptance.
  - Shadow slot: the bundle presented in the cycle of the redirect pulse is squashed (no writeback, no memory access, no redirect).
  - Load/store: addr = rs1+imm. dmem_addr = {addr[31:2],2'b00}. Assert dmem_ready on the next cycle, ex_stall=1, go to MEM_WAIT.
  - Store byte/half/word: wstrb = 0001<<addr[1:0], 0011<<addr[1:0], 1111 respectively; wdata is rs2 replicated into the lanes.
- MEM_WAIT:
  - dmem_ready, addr, rw, wstrb and wdata are held stable until dmem_valid=1.
  - On dmem_valid: deassert dmem_ready and ex_stall, return to IDLE.
  - Load: wb_valid on the cycle after dmem_valid, data extracted per addr[1:0]. funct3 000 LB and 001 LH sign-extend; 100 LBU and 101 LHU zero-extend; 010 LW.
  - Store: no writeback.
  - dmem_valid may arrive on the first cycle dmem_ready is asserted; this gives a 1-cycle stall.
- Writeback with rd=x0 is suppressed (wb_valid=0).
- Faults set ex_exception (sticky until reset), and the faulting instruction has no side effects:
  - LH/LHU/SH with addr[0]=1;
  - LW/SW with addr[1:0]!=0;
  - redirect target with bit[1]=1;
  - illegal funct3 for load, store or branch.
- id_valid=0: nothing happens; wb_valid=0 on the next cycle.

Decomposition:
- Shared package (opcode.vh): funct3 encodings (OP_ADD, OP_SLL, OP_SR, branch and load/store width codes) and RESETVEC.
- One sub-module: ex_alu, the combinational ALU (op, subtype, a, b -> result).
- Branch compare, load extract and store align stay inline.

Test Plan:
- ADDI: rs1=5, imm=-7, imm_sel=1, rd=3 -> next cycle wb_valid=1, wb_dst=3, wb_data=32'hFFFF_FFFE.
- SRA: rs1=32'h8000_0000, rs2=4, subtype=1 -> wb_data=32'hF800_0000. SRL with the same operands -> 32'h0800_0000.
- BNE taken: pc=32'h100, imm=32'h20, rs1=1, rs2=2 -> redirect=1, redirect_pc=32'h120; the next bundle (ADDI rd=4) is squashed with no wb_valid.
- LB: rs1=32'h1001, imm=0, dmem_rdata=32'h0000_8000, dmem_valid delayed 3 cycles -> dmem_addr=32'h1000 held stable and ex_stall=1 for 4 cycles; then wb_data=32'hFFFF_FF80.
- SH: rs1=32'h2002, rs2=32'h1234_ABCD -> dmem_rw=1, wstrb=4'b1100, wdata[31:16]=16'hABCD; no wb_valid.
- LW: addr=32'h3002 -> ex_exception=1, no dmem_ready. resetb pulsed low during a MEM_WAIT -> all outputs 0 immediately; a late dmem_valid is ignored.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared encodings for the RV32I execute stage.
// funct3 codes, reset vector, FSM states and the pending memory bundle.
package ex_stage_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SR   = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_MEM_WAIT = 1'b1;

  typedef struct packed {
    logic       load;
    logic [2:0] f3;
    logic [1:0] off;
    logic [4:0] dst;
  } mem_pend_t;

  function automatic logic [31:0] ld_extract(
    input logic [2:0]  f3,
    input logic [1:0]  off,
    input logic [31:0] rdata
  );
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      MEM_B:   ld_extract = {{24{sh[7]}}, sh[7:0]};
      MEM_H:   ld_extract = {{16{sh[15]}}, sh[15:0]};
      MEM_BU:  ld_extract = {24'b0, sh[7:0]};
      MEM_HU:  ld_extract = {16'b0, sh[15:0]};
      default: ld_extract = sh;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational RV32I ALU.
// funct3 selects the operation; subtype picks SUB and SRA.
module ex_alu
  import ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic            subtype,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  logic signed [XLEN-1:0] sra;

  assign sra = $signed(a) >>> b[4:0];

  always_comb begin
    result = '0;
    unique case (op)
      OP_ADD:  result = subtype ? a - b : a + b;
      OP_SLL:  result = a << b[4:0];
      OP_SLT:  result[0] = $signed(a) < $signed(b);
      OP_SLTU: result[0] = a < b;
      OP_XOR:  result = a ^ b;
      OP_SR:   result = subtype ? sra : a >> b[4:0];
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, branch/jump resolution, data-memory access.
// Drives the registered writeback bundle, fetch redirect and decode stall.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESETVEC = RESET_VEC
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_imm_sel,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [4:0]      id_dst,
  input  logic [2:0]      id_alu_op,
  input  logic            id_subtype,
  input  logic            id_memwr,
  input  logic            id_mem2reg,
  input  logic            id_alu,
  input  logic            id_lui,
  input  logic            id_auipc,
  input  logic            id_jal,
  input  logic            id_jalr,
  input  logic            id_branch,
  output logic            ex_stall,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            dmem_ready,
  input  logic            dmem_valid,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_rw,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_dst,
  output logic [XLEN-1:0] wb_data,
  output logic            ex_exception
);

  logic            state;
  mem_pend_t       pend;
  logic            accept;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] tgt;
  logic [1:0]      size;
  logic            mis;
  logic            ld_ok;
  logic            st_ok;
  logic            br_ok;
  logic            br_taken;
  logic            nxt_wb;
  logic [XLEN-1:0] nxt_data;
  logic            nxt_redir;
  logic            nxt_mem;
  logic            nxt_load;
  logic            fault;
  logic [3:0]      nxt_wstrb;
  logic [XLEN-1:0] nxt_wdata;

  // The bundle arriving with the redirect pulse is the wrong-path shadow.
  assign accept = id_valid & ~redirect & (state == S_IDLE);
  assign op_b   = id_imm_sel ? id_imm : id_rs2_data;
  assign addr   = id_rs1_data + id_imm;
  assign pc4    = id_pc + 32'd4;
  assign tgt    = id_jalr ? (addr & ~32'd1) : id_pc + id_imm;
  assign size   = id_alu_op[1:0];
  assign mis    = (size == 2'd1 & addr[0]) |
                  (size == 2'd2 & |addr[1:0]);
  assign ld_ok  = (size != 2'd3) & ~(id_alu_op[2] & size == 2'd2);
  assign st_ok  = (size != 2'd3) & ~id_alu_op[2];

  ex_alu #(.XLEN(XLEN)) u_alu (
    .op      (id_alu_op),
    .subtype (id_subtype),
    .a       (id_rs1_data),
    .b       (op_b),
    .result  (alu_res)
  );

  always_comb begin
    br_ok    = 1'b1;
    br_taken = 1'b0;
    case (id_alu_op)
      BR_EQ:  br_taken = id_rs1_data == id_rs2_data;
      BR_NE:  br_taken = id_rs1_data != id_rs2_data;
      BR_LT:  br_taken = $signed(id_rs1_data) < $signed(id_rs2_data);
      BR_GE:  br_taken = $signed(id_rs1_data) >= $signed(id_rs2_data);
      BR_LTU: br_taken = id_rs1_data < id_rs2_data;
      BR_GEU: br_taken = id_rs1_data >= id_rs2_data;
      default: br_ok = 1'b0;
    endcase
  end

  always_comb begin
    nxt_wstrb = 4'b1111;
    nxt_wdata = id_rs2_data;
    case (size)
      2'd0: begin
        nxt_wstrb = 4'b0001 << addr[1:0];
        nxt_wdata = {4{id_rs2_data[7:0]}};
      end
      2'd1: begin
        nxt_wstrb = 4'b0011 << addr[1:0];
        nxt_wdata = {2{id_rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt_wb    = 1'b0;
    nxt_data  = '0;
    nxt_redir = 1'b0;
    nxt_mem   = 1'b0;
    nxt_load  = 1'b0;
    fault     = 1'b0;
    if (accept) begin
      unique case (1'b1)
        id_alu: begin
          nxt_wb   = 1'b1;
          nxt_data = alu_res;
        end
        id_lui: begin
          nxt_wb   = 1'b1;
          nxt_data = id_imm;
        end
        id_auipc: begin
          nxt_wb   = 1'b1;
          nxt_data = id_pc + id_imm;
        end
        id_jal, id_jalr: begin
          nxt_wb    = 1'b1;
          nxt_data  = pc4;
          nxt_redir = 1'b1;
        end
        id_branch: begin
          fault     = ~br_ok;
          nxt_redir = br_ok & br_taken;
        end
        id_mem2reg: begin
          fault    = ~ld_ok | mis;
          nxt_mem  = ~fault;
          nxt_load = 1'b1;
        end
        id_memwr: begin
          fault   = ~st_ok | mis;
          nxt_mem = ~fault;
        end
        default: ;
      endcase
      // A misaligned target kills the link write as well as the jump.
      if (nxt_redir && tgt[1]) begin
        fault     = 1'b1;
        nxt_redir = 1'b0;
        nxt_wb    = 1'b0;
      end
      if (id_dst == 5'd0) nxt_wb = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state        <= S_IDLE;
      pend         <= '0;
      ex_stall     <= 1'b0;
      redirect     <= 1'b0;
      redirect_pc  <= RESETVEC;
      dmem_ready   <= 1'b0;
      dmem_addr    <= '0;
      dmem_rw      <= 1'b0;
      dmem_wstrb   <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_dst       <= '0;
      wb_data      <= '0;
      ex_exception <= 1'b0;
    end else begin
      redirect <= nxt_redir;
      wb_valid <= nxt_wb;
      if (nxt_redir) redirect_pc <= tgt;
      if (nxt_wb) begin
        wb_dst  <= id_dst;
        wb_data <= nxt_data;
      end
      if (fault) ex_exception <= 1'b1;
      case (state)
        S_IDLE: begin
          if (nxt_mem) begin
            state      <= S_MEM_WAIT;
            ex_stall   <= 1'b1;
            dmem_ready <= 1'b1;
            dmem_addr  <= {addr[XLEN-1:2], 2'b00};
            dmem_rw    <= ~nxt_load;
            dmem_wstrb <= nxt_load ? 4'b0000 : nxt_wstrb;
            dmem_wdata <= nxt_load ? '0 : nxt_wdata;
            pend       <= '{load: nxt_load, f3: id_alu_op,
                            off: addr[1:0], dst: id_dst};
          end
        end
        default: begin
          if (dmem_valid) begin
            state      <= S_IDLE;
            ex_stall   <= 1'b0;
            dmem_ready <= 1'b0;
            if (pend.load && pend.dst != 5'd0) begin
              wb_valid <= 1'b1;
              wb_dst   <= pend.dst;
              wb_data  <= ld_extract(pend.f3, pend.off, dmem_rdata);
            end
          end
        end
      endcase
    end
  end

endmodule
